// File: rtl/ccc_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccc_mon_pkg
// Brief    : Shared types and default constants for the CCC lock monitor.
//            State encoding is visible on the STATE port, so the values below
//            are part of the external interface.
// Revision : 1.0 - initial release
// ============================================================================
package ccc_mon_pkg;

  // Monitor states, encoded as exposed on STATE
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_QUALIFY   = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } mon_state_e;

  // Default parameter values for ccc_lock_monitor
  localparam int unsigned c_lock_sync_stages_def = 2;
  localparam int unsigned c_stable_cycles_def    = 1024;
  localparam int unsigned c_rst_hold_cycles_def  = 16;
  localparam int unsigned c_cnt_w_def            = 16;

  // Width needed to count 0..n-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lock_sync.sv
`default_nettype none
// ============================================================================
// Module   : lock_sync
// Brief    : Multi-flop synchronizer bringing the asynchronous CCC LOCK
//            indicator into the CLK domain. Cleared by the monitor reset.
// Revision : 1.0 - initial release
// ============================================================================
module lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchronizer chain
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], D};
    end
  end

  assign Q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ccc_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ccc_lock_monitor
// Brief    : Watches the CCC LOCK indicator, holds downstream logic in reset
//            until LOCK has been stable for STABLE_CYCLES, and forces a
//            RST_HOLD_CYCLES reset pulse on any lock loss while running.
//            Lock losses are flagged (sticky LOCK_LOST) and counted.
// Config   : CCC_LOCK_MON_LOSS_CNT_EN - when defined, LOSS_CNT is a
//            saturating lock-loss counter; otherwise LOSS_CNT is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ccc_lock_monitor
  import ccc_mon_pkg::*;
#(
  parameter int unsigned LOCK_SYNC_STAGES = c_lock_sync_stages_def,
  parameter int unsigned STABLE_CYCLES    = c_stable_cycles_def,
  parameter int unsigned RST_HOLD_CYCLES  = c_rst_hold_cycles_def,
  parameter int unsigned CNT_W            = c_cnt_w_def
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             LOCK,
  input  logic             CLR_CNT,
  output logic             RST_OUT_N,
  output logic             READY,
  output logic             LOCK_LOST,
  output logic [CNT_W-1:0] LOSS_CNT,
  output logic [1:0]       STATE
);

  localparam int unsigned STB_W = cnt_width(STABLE_CYCLES);
  localparam int unsigned HLD_W = cnt_width(RST_HOLD_CYCLES);
  localparam logic [STB_W-1:0] c_stb_last = STB_W'(STABLE_CYCLES - 1);
  localparam logic [HLD_W-1:0] c_hld_last = HLD_W'(RST_HOLD_CYCLES - 1);

  logic             lock_s;
  mon_state_e       state_q;
  logic [STB_W-1:0] stb_cnt_q;
  logic [HLD_W-1:0] hld_cnt_q;
  logic             rst_out_n_q;
  logic             ready_q;
  logic             lock_lost_q;
  logic             loss_evt;

  lock_sync #(
    .STAGES (LOCK_SYNC_STAGES)
  ) u_lock_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .D      (LOCK),
    .Q      (lock_s)
  );

  // A loss event is a synchronized lock drop observed while running
  assign loss_evt = (state_q == ST_RUN) && !lock_s;

  // Lock qualification / fault-hold FSM with registered reset and ready outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= ST_WAIT_LOCK;
      stb_cnt_q   <= '0;
      hld_cnt_q   <= '0;
      rst_out_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_q   <= ST_QUALIFY;
            stb_cnt_q <= '0;
          end
        end
        ST_QUALIFY: begin
          if (!lock_s) begin
            state_q   <= ST_WAIT_LOCK;
            stb_cnt_q <= '0;
          end else if (stb_cnt_q == c_stb_last) begin
            state_q     <= ST_RUN;
            rst_out_n_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            stb_cnt_q <= stb_cnt_q + STB_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_q     <= ST_FAULT;
            hld_cnt_q   <= '0;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
          end
        end
        ST_FAULT: begin
          // Hold time is fixed; LOCK is deliberately ignored here
          if (hld_cnt_q == c_hld_last) begin
            state_q <= ST_WAIT_LOCK;
          end else begin
            hld_cnt_q <= hld_cnt_q + HLD_W'(1);
          end
        end
        default: begin
          state_q     <= ST_WAIT_LOCK;
          rst_out_n_q <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  // Sticky loss flag; a coincident loss event takes priority over a clear
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      lock_lost_q <= 1'b0;
    end else if (loss_evt) begin
      lock_lost_q <= 1'b1;
    end else if (CLR_CNT) begin
      lock_lost_q <= 1'b0;
    end
  end

`ifdef CCC_LOCK_MON_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt_q;

  // Saturating loss counter; a coincident loss event takes priority over a clear
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      loss_cnt_q <= '0;
    end else if (loss_evt) begin
      if (loss_cnt_q != '1) begin
        loss_cnt_q <= loss_cnt_q + CNT_W'(1);
      end
    end else if (CLR_CNT) begin
      loss_cnt_q <= '0;
    end
  end

  assign LOSS_CNT = loss_cnt_q;
`else
  assign LOSS_CNT = '0;
`endif

  assign RST_OUT_N = rst_out_n_q;
  assign READY     = ready_q;
  assign LOCK_LOST = lock_lost_q;
  assign STATE     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ccc_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccc_lock_monitor
// Brief    : Self-checking bench for ccc_lock_monitor (SYNC=2, STABLE=8,
//            HOLD=4, CNT_W=4). Directed vector table, hand-written corner
//            sequences and random LOCK/CLR_CNT traffic checked against a
//            behavioural model. Expectations follow CCC_LOCK_MON_LOSS_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccc_lock_monitor;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int CW     = 4;
`ifdef CCC_LOCK_MON_LOSS_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int CNT_ONE = CNT_EN;

  logic          CLK     = 1'b0;
  logic          RESETN  = 1'b0;
  logic          LOCK    = 1'b0;
  logic          CLR_CNT = 1'b0;
  logic          RST_OUT_N;
  logic          READY;
  logic          LOCK_LOST;
  logic [CW-1:0] LOSS_CNT;
  logic [1:0]    STATE;

  int checks = 0;
  int errors = 0;

  ccc_lock_monitor #(
    .LOCK_SYNC_STAGES (SYNC),
    .STABLE_CYCLES    (STABLE),
    .RST_HOLD_CYCLES  (HOLD),
    .CNT_W            (CW)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .LOCK      (LOCK),
    .CLR_CNT   (CLR_CNT),
    .RST_OUT_N (RST_OUT_N),
    .READY     (READY),
    .LOCK_LOST (LOCK_LOST),
    .LOSS_CNT  (LOSS_CNT),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  bit hist[$];          // LOCK as sampled at each past edge
  int m_fault_left;     // remaining forced-reset cycles
  int m_streak;         // consecutive qualifying edges seen with lock high
  bit m_run;
  bit m_lost;
  int m_cnt;

  task automatic model_reset();
    hist.delete();
    m_fault_left = 0;
    m_streak     = 0;
    m_run        = 0;
    m_lost       = 0;
    m_cnt        = 0;
  endtask

  task automatic model_step(input bit lk, input bit clr);
    bit ls;
    bit loss;
    loss = 0;
    ls = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
    hist.push_back(lk);
    if (hist.size() > 8) void'(hist.pop_front());
    if (m_fault_left > 0) begin
      m_fault_left--;
    end else if (m_run) begin
      if (!ls) begin
        m_run        = 0;
        m_fault_left = HOLD;
        loss         = 1;
      end
    end else if (ls) begin
      m_streak++;
      // one edge to leave WAIT_LOCK, then STABLE qualifying edges
      if (m_streak == STABLE + 1) begin
        m_run    = 1;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    if (loss) begin
      m_lost = 1;
      if (CNT_EN != 0 && m_cnt < CNT_MAX) m_cnt++;
    end else if (clr) begin
      m_lost = 0;
      m_cnt  = 0;
    end
  endtask

  function automatic int m_state();
    if (m_run)            return 2;
    if (m_fault_left > 0) return 3;
    if (m_streak > 0)     return 1;
    return 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".STATE"},     {30'd0, STATE},     m_state());
    chk({tag, ".RST_OUT_N"}, {31'd0, RST_OUT_N}, {31'd0, m_run});
    chk({tag, ".READY"},     {31'd0, READY},     {31'd0, m_run});
    chk({tag, ".LOCK_LOST"}, {31'd0, LOCK_LOST}, {31'd0, m_lost});
    chk({tag, ".LOSS_CNT"},  {28'd0, LOSS_CNT},  m_cnt);
  endtask

  // Drive inputs for the coming edge, advance one cycle, check after the edge
  task automatic tick(input bit lk, input bit clr, input string tag);
    LOCK    = lk;
    CLR_CNT = clr;
    @(posedge CLK);
    model_step(lk, clr);
    #1;
    compare_model(tag);
  endtask

  // Returns at edge 0 + 1ns with LOCK low and the model cleared
  task automatic do_reset();
    RESETN  = 1'b0;
    LOCK    = 1'b0;
    CLR_CNT = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.STATE",     {30'd0, STATE},     0);
    chk("reset.RST_OUT_N", {31'd0, RST_OUT_N}, 0);
    chk("reset.READY",     {31'd0, READY},     0);
    chk("reset.LOCK_LOST", {31'd0, LOCK_LOST}, 0);
    chk("reset.LOSS_CNT",  {28'd0, LOSS_CNT},  0);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic loss_cycle(input string tag);
    repeat (HOLD + SYNC + 1) tick(1'b0, 1'b0, tag);
    repeat (SYNC + 1 + STABLE) tick(1'b1, 1'b0, tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       lk;
    bit       clr;
    bit       chk;
    int       st;
    bit       rstn;
    bit       lost;
    int       cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit lk, bit chkv, int st, bit rstn, bit lost, int cnt);
    vec_t v;
    v.lk = lk; v.clr = 1'b0; v.chk = chkv; v.st = st;
    v.rstn = rstn; v.lost = lost; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    bit lk;
    bit cl;

    // Entry e is applied after edge e-1 and checked after edge e.
    // LOCK rises after edge 0, drops after edge 14 (N=14).
    for (int e = 1; e <= 21; e++) begin
      lk = (e <= 14);
      case (e)
        10:      tbl.push_back(mk(lk, 1'b1, 1, 1'b0, 1'b0, 0));
        11:      tbl.push_back(mk(lk, 1'b1, 2, 1'b1, 1'b0, 0));
        16:      tbl.push_back(mk(lk, 1'b1, 2, 1'b1, 1'b0, 0));
        17:      tbl.push_back(mk(lk, 1'b1, 3, 1'b0, 1'b1, CNT_ONE));
        20:      tbl.push_back(mk(lk, 1'b1, 3, 1'b0, 1'b1, CNT_ONE));
        21:      tbl.push_back(mk(lk, 1'b1, 0, 1'b0, 1'b1, CNT_ONE));
        default: tbl.push_back(mk(lk, 1'b0, 0, 1'b0, 1'b0, 0));
      endcase
    end

    // Acquire and loss in RUN
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].lk, tbl[i].clr, "tbl");
      if (tbl[i].chk) begin
        chk($sformatf("tbl[%0d].STATE", i),     {30'd0, STATE},     tbl[i].st);
        chk($sformatf("tbl[%0d].RST_OUT_N", i), {31'd0, RST_OUT_N}, {31'd0, tbl[i].rstn});
        chk($sformatf("tbl[%0d].READY", i),     {31'd0, READY},     {31'd0, tbl[i].rstn});
        chk($sformatf("tbl[%0d].LOCK_LOST", i), {31'd0, LOCK_LOST}, {31'd0, tbl[i].lost});
        chk($sformatf("tbl[%0d].LOSS_CNT", i),  {28'd0, LOSS_CNT},  tbl[i].cnt);
      end
    end

    // Glitch during qualification: high 5, low 1, high
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      tick((e != 6), 1'b0, "glitch");
      if (e == 8)  chk("glitch.back_to_wait", {30'd0, STATE}, 0);
      if (e == 16) chk("glitch.rstn_e16", {31'd0, RST_OUT_N}, 0);
      if (e == 17) chk("glitch.rstn_e17", {31'd0, RST_OUT_N}, 1);
    end
    chk("glitch.lost_untouched", {31'd0, LOCK_LOST}, 0);

    // Saturation, clear, and clear coinciding with a loss
    do_reset();
    repeat (SYNC + 1 + STABLE) tick(1'b1, 1'b0, "sat.acq");
    for (int k = 0; k < 17; k++) loss_cycle("sat");
    chk("sat.LOSS_CNT",  {28'd0, LOSS_CNT},  (CNT_EN != 0) ? CNT_MAX : 0);
    chk("sat.LOCK_LOST", {31'd0, LOCK_LOST}, 1);
    tick(1'b1, 1'b1, "clr");
    chk("clr.LOSS_CNT",  {28'd0, LOSS_CNT},  0);
    chk("clr.LOCK_LOST", {31'd0, LOCK_LOST}, 0);
    tick(1'b0, 1'b0, "clrloss");
    tick(1'b0, 1'b0, "clrloss");
    tick(1'b0, 1'b1, "clrloss");
    chk("clrloss.LOSS_CNT",  {28'd0, LOSS_CNT},  CNT_ONE);
    chk("clrloss.LOCK_LOST", {31'd0, LOCK_LOST}, 1);
    chk("clrloss.STATE",     {30'd0, STATE},     3);
    repeat (HOLD) tick(1'b0, 1'b0, "clrloss.hold");
    repeat (SYNC + 1 + STABLE) tick(1'b1, 1'b0, "clrloss.reacq");

    // Asynchronous reset in RUN, then full re-qualification
    chk("async.pre_rstn", {31'd0, RST_OUT_N}, 1);
    #3;
    RESETN = 1'b0;
    #1;
    chk("async.RST_OUT_N", {31'd0, RST_OUT_N}, 0);
    chk("async.READY",     {31'd0, READY},     0);
    chk("async.STATE",     {30'd0, STATE},     0);
    chk("async.LOSS_CNT",  {28'd0, LOSS_CNT},  0);
    chk("async.LOCK_LOST", {31'd0, LOCK_LOST}, 0);
    @(posedge CLK);
    #1;
    do_reset();
    for (int e = 1; e <= SYNC + 1 + STABLE; e++) begin
      tick(1'b1, 1'b0, "requal");
      if (e == SYNC + STABLE) chk("requal.rstn_early", {31'd0, RST_OUT_N}, 0);
    end
    chk("requal.rstn", {31'd0, RST_OUT_N}, 1);

    // Random LOCK / CLR_CNT traffic against the model
    lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 8) lk = ~lk;
      cl = ($urandom_range(0, 99) < 3);
      tick(lk, cl, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccc_lock_monitor.md
CCC_LOCK_MONITOR -- requirements
Module: ccc_lock_monitor

Interface
REQ-001 Parameter LOCK_SYNC_STAGES, default 2, SHALL set the flop count of the LOCK synchronizer (legal range 2..4).
REQ-002 Parameter STABLE_CYCLES, default 1024, SHALL set the cycles LOCK must stay high before reset release (legal range >= 1).
REQ-003 Parameter RST_HOLD_CYCLES, default 16, SHALL set the cycles reset is held after a lock loss (legal range >= 1).
REQ-004 Parameter CNT_W, default 16, SHALL set the width of the lock-loss counter.
REQ-005 CLK  in  1  SHALL be the single clock (a CCC global output, e.g. GL0).
REQ-006 RESETN  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 LOCK  in  1  SHALL be the CCC lock indicator, asynchronous to CLK.
REQ-008 CLR_CNT  in  1  SHALL be a one-cycle pulse that clears LOSS_CNT and LOCK_LOST.
REQ-009 RST_OUT_N  out  1  SHALL be the active-low reset for downstream logic.
REQ-010 READY  out  1  SHALL be high only while the state is RUN.
REQ-011 LOCK_LOST  out  1  SHALL be a sticky flag set on any lock loss in RUN.
REQ-012 LOSS_CNT  out  CNT_W  SHALL be the saturating count of lock losses in RUN.
REQ-013 STATE  out  2  SHALL expose the state: WAIT_LOCK=0, QUALIFY=1, RUN=2, FAULT=3.

Function
REQ-014 LOCK SHALL pass through a LOCK_SYNC_STAGES-flop synchronizer; every rule below uses the synchronized value (lock_s).
REQ-015 WAIT_LOCK with lock_s=1 SHALL go to QUALIFY on the next edge and clear the stable counter to 0.
REQ-016 QUALIFY with lock_s=0 SHALL return to WAIT_LOCK on the next edge and clear the stable counter.
REQ-017 QUALIFY with lock_s=1 and counter = STABLE_CYCLES-1 SHALL enter RUN on the next edge; otherwise the counter SHALL increment.
REQ-018 Entering RUN SHALL set RST_OUT_N=1 and READY=1 on the same edge; both outputs are registered and never driven combinationally.
REQ-019 Timing from an LOCK rise that meets setup SHALL be LOCK_SYNC_STAGES+1+STABLE_CYCLES edges to RST_OUT_N high.
REQ-020 RUN with lock_s=0 SHALL, on the next edge:
 - enter FAULT;
 - drive RST_OUT_N=0 and READY=0;
 - set LOCK_LOST;
 - increment LOSS_CNT, holding it at all-ones once saturated.
REQ-021 FAULT SHALL last exactly RST_HOLD_CYCLES cycles regardless of LOCK, then go to WAIT_LOCK.
REQ-022 RST_OUT_N SHALL be 0 in every state except RUN.
REQ-023 CLR_CNT SHALL zero LOSS_CNT and LOCK_LOST on the next edge.
REQ-024 If CLR_CNT coincides with a loss event, the event SHALL win: LOSS_CNT=1 and LOCK_LOST=1.
REQ-025 LOCK glitches shorter than STABLE_CYCLES during QUALIFY SHALL NOT release reset.
REQ-026 LOSS_CNT and LOCK_LOST SHALL be unaffected by lock drops in WAIT_LOCK or QUALIFY.

Reset
REQ-027 RESETN low SHALL asynchronously force all of the following:
 - state=WAIT_LOCK;
 - synchronizer and counters to 0;
 - RST_OUT_N=0, READY=0, LOCK_LOST=0, LOSS_CNT=0.
REQ-028 RESETN low mid-RUN SHALL drop RST_OUT_N immediately, without waiting for a clock edge.
REQ-029 After RESETN deassertion, operation SHALL restart from WAIT_LOCK with full qualification.

Configuration
REQ-030 Macro CCC_LOCK_MON_LOSS_CNT_EN SHALL control the loss counter:
 - defined: LOSS_CNT is implemented per REQ-020/023/024;
 - undefined: LOSS_CNT is tied to 0 with no counter flops, while LOCK_LOST and all other behaviour are unchanged.

Structure
REQ-031 Package ccc_mon_pkg SHALL hold the state typedef and encodings, plus default constants for the four parameters.
REQ-032 The synchronizer SHALL be a separate sub-module, lock_sync, with parameter STAGES, inputs CLK, RESETN, D and output Q.

Verification (bench parameters: SYNC=2, STABLE=8, HOLD=4, CNT_W=4)
REQ-033 Lock acquire: RESETN released, LOCK rises at edge 0 and stays high -> RST_OUT_N and READY rise at edge 11; STATE=2.
REQ-034 Glitch in qualify: LOCK high 5 cycles, low 1, then high -> STATE returns to 0, and RST_OUT_N rises 11 edges after the second rise.
REQ-035 Loss in RUN: LOCK drops at edge N -> at edge N+3, RST_OUT_N=0, STATE=3, LOSS_CNT=1, LOCK_LOST=1; STATE=0 at edge N+7.
REQ-036 Saturation and clear:
 - 17 loss cycles -> LOSS_CNT=15;
 - CLR_CNT pulse -> LOSS_CNT=0 and LOCK_LOST=0;
 - CLR_CNT on the loss edge -> LOSS_CNT=1.
REQ-037 Async reset in RUN: RESETN low mid-cycle -> RST_OUT_N=0 before the next edge, LOSS_CNT=0.
REQ-038 Macro off: repeat REQ-035 -> LOSS_CNT stays 0, LOCK_LOST=1.
